// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves operands with EX/WB forwarding and buffers up to two ops.
// The optional stall_cnt port is enabled with `define ALU_ISSUE_STALL_CNT_EN.
module alu_issue_stage #(
    parameter int N    = 32,
    parameter int RIDX = 5
) (
`ifdef ALU_ISSUE_STALL_CNT_EN
    output logic [31:0]     stall_cnt,
`endif
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RIDX-1:0] in_rs1,
    input  logic [RIDX-1:0] in_rs2,
    input  logic [N-1:0]    in_rs1_data,
    input  logic [N-1:0]    in_rs2_data,
    input  logic [N-1:0]    in_pc,
    input  logic [N-1:0]    in_imm,
    input  logic            in_a_sel,
    input  logic            in_b_sel,
    input  logic [3:0]      in_ctrl,
    input  logic            in_cin,
    input  logic            fwd_ex_en,
    input  logic [RIDX-1:0] fwd_ex_rd,
    input  logic [N-1:0]    fwd_ex_data,
    input  logic            fwd_wb_en,
    input  logic [RIDX-1:0] fwd_wb_rd,
    input  logic [N-1:0]    fwd_wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    A,
    output logic [N-1:0]    B,
    output logic [3:0]      Ctrl,
    output logic            Cin
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state;
    logic            in_xfer;
    logic            out_xfer;
    logic [N-1:0]    cap_a;
    logic [N-1:0]    cap_b;
    logic            cap_cin;
    logic [N-1:0]    skid_a;
    logic [N-1:0]    skid_b;
    logic [3:0]      skid_ctrl;
    logic            skid_cin;

    // EX wins over WB; x0 is hardwired and never takes a forwarded value.
    function automatic logic [N-1:0] resolve(
        input logic [RIDX-1:0] idx,
        input logic [N-1:0]    rf_data,
        input logic            ex_en,
        input logic [RIDX-1:0] ex_rd,
        input logic [N-1:0]    ex_data,
        input logic            wb_en,
        input logic [RIDX-1:0] wb_rd,
        input logic [N-1:0]    wb_data
    );
        if (idx != '0 && ex_en && ex_rd == idx)
            return ex_data;
        else if (idx != '0 && wb_en && wb_rd == idx)
            return wb_data;
        else
            return rf_data;
    endfunction

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        cap_a   = in_a_sel ? in_pc
                           : resolve(in_rs1, in_rs1_data, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                                     fwd_wb_en, fwd_wb_rd, fwd_wb_data);
        cap_b   = in_b_sel ? in_imm
                           : resolve(in_rs2, in_rs2_data, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                                     fwd_wb_en, fwd_wb_rd, fwd_wb_data);
        cap_cin = (in_ctrl == 4'b0000) ? in_cin : 1'b0;
    end

    // Control and output register: state tracks the number of buffered ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            A         <= '0;
            B         <= '0;
            Ctrl      <= 4'b0000;
            Cin       <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        A         <= cap_a;
                        B         <= cap_b;
                        Ctrl      <= in_ctrl;
                        Cin       <= cap_cin;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        A    <= cap_a;
                        B    <= cap_b;
                        Ctrl <= in_ctrl;
                        Cin  <= cap_cin;
                    end else if (in_xfer) begin
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        A        <= skid_a;
                        B        <= skid_b;
                        Ctrl     <= skid_ctrl;
                        Cin      <= skid_cin;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Skid data needs no reset: it is only read once the FULL state has loaded it.
    always_ff @(posedge clk) begin
        if (!flush && state == ONE && in_xfer && !out_xfer) begin
            skid_a    <= cap_a;
            skid_b    <= cap_b;
            skid_ctrl <= in_ctrl;
            skid_cin  <= cap_cin;
        end
    end

`ifdef ALU_ISSUE_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed test-plan steps followed by random traffic
// checked against a queue-based model of the issue stage.
module tb_alu_issue_stage;
    localparam int N    = 32;
    localparam int RIDX = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [RIDX-1:0] in_rs1, in_rs2;
    logic [N-1:0]    in_rs1_data, in_rs2_data, in_pc, in_imm;
    logic            in_a_sel, in_b_sel;
    logic [3:0]      in_ctrl;
    logic            in_cin;
    logic            fwd_ex_en, fwd_wb_en;
    logic [RIDX-1:0] fwd_ex_rd, fwd_wb_rd;
    logic [N-1:0]    fwd_ex_data, fwd_wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    A, B;
    logic [3:0]      Ctrl;
    logic            Cin;
`ifdef ALU_ISSUE_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    alu_issue_stage #(.N(N), .RIDX(RIDX)) dut (
`ifdef ALU_ISSUE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_ctrl(in_ctrl), .in_cin(in_cin),
        .fwd_ex_en(fwd_ex_en), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .Ctrl(Ctrl), .Cin(Cin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        cin;
    } op_t;

    op_t         q[$];
    int unsigned stall_model;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] src_val(input logic [RIDX-1:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (fwd_ex_en && fwd_ex_rd == idx) return fwd_ex_data;
        if (fwd_wb_en && fwd_wb_rd == idx) return fwd_wb_data;
        return rf;
    endfunction

    function automatic op_t model_op();
        op_t o;
        o.a    = in_a_sel ? in_pc : src_val(in_rs1, in_rs1_data);
        o.b    = in_b_sel ? in_imm : src_val(in_rs2, in_rs2_data);
        o.ctrl = in_ctrl;
        o.cin  = (in_ctrl == 4'd0) ? in_cin : 1'b0;
        return o;
    endfunction

    task automatic check_state();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("A", A, q[0].a);
            chk("B", B, q[0].b);
            chk("Ctrl", {28'd0, Ctrl}, {28'd0, q[0].ctrl});
            chk("Cin", {31'd0, Cin}, {31'd0, q[0].cin});
        end
`ifdef ALU_ISSUE_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_model);
`endif
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        bit  ix, ox;
        op_t n;
        ix = in_valid && (q.size() < 2);
        ox = (q.size() > 0) && out_ready;
        n  = model_op();
        if (q.size() > 0 && !out_ready) stall_model++;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(n);
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic set_op(input logic [RIDX-1:0] r1, input logic [RIDX-1:0] r2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic asel, input logic bsel,
                          input logic [3:0] ctrl, input logic cin);
        in_rs1 = r1; in_rs2 = r2; in_rs1_data = d1; in_rs2_data = d2;
        in_pc = pc; in_imm = imm; in_a_sel = asel; in_b_sel = bsel;
        in_ctrl = ctrl; in_cin = cin;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; stall_model = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        fwd_ex_en = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
        fwd_wb_en = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1'b0);
        @(negedge clk); @(negedge clk);
        check_state();
        chk("reset_A", A, 32'd0);
        chk("reset_Ctrl", {28'd0, Ctrl}, 32'd0);
        rst = 1'b0;

        // Single op, then Cin masking for a non-add control code
        set_op(1, 2, 32'd5, 32'd3, 0, 0, 0, 0, 4'b0000, 1'b1);
        in_valid = 1'b1;
        cycle();
        chk("tp_single_A", A, 32'd5);
        chk("tp_single_B", B, 32'd3);
        chk("tp_single_Cin", {31'd0, Cin}, 32'd1);
        set_op(1, 2, 32'd9, 32'd4, 0, 0, 0, 0, 4'b0011, 1'b1);
        cycle();
        chk("tp_cin_mask", {31'd0, Cin}, 32'd0);
        chk("tp_ctrl_pass", {28'd0, Ctrl}, 32'd3);

        // Forwarding priority and x0
        set_op(7, 3, 32'd1, 32'd2, 0, 0, 0, 0, 4'd1, 1'b0);
        fwd_ex_en = 1'b1; fwd_ex_rd = 7; fwd_ex_data = 32'hAA;
        fwd_wb_en = 1'b1; fwd_wb_rd = 7; fwd_wb_data = 32'hBB;
        cycle();
        chk("tp_fwd_prio", A, 32'hAA);
        set_op(0, 3, 32'd0, 32'd2, 0, 0, 0, 0, 4'd1, 1'b0);
        fwd_ex_rd = 0; fwd_ex_data = 32'h55; fwd_wb_en = 1'b0;
        cycle();
        chk("tp_fwd_x0", A, 32'd0);
        fwd_ex_en = 1'b0;

        // Operand select
        set_op(1, 2, 32'd1, 32'd2, 32'h100, 32'hFFFFF800, 1, 1, 4'd2, 1'b0);
        cycle();
        chk("tp_sel_A", A, 32'h100);
        chk("tp_sel_B", B, 32'hFFFFF800);
        in_valid = 1'b0;
        cycle();

        // Backpressure: X then Y into a stalled stage
        out_ready = 1'b0; in_valid = 1'b1;
        set_op(1, 2, 32'h11, 32'h12, 0, 0, 0, 0, 4'd4, 1'b0);
        cycle();
        set_op(1, 2, 32'h21, 32'h22, 0, 0, 0, 0, 4'd5, 1'b0);
        cycle();
        chk("tp_bp_full", {31'd0, in_ready}, 32'd0);
        chk("tp_bp_hold", A, 32'h11);
        in_valid = 1'b0;
        cycle();
        chk("tp_bp_hold2", A, 32'h11);
        out_ready = 1'b1;
        cycle();
        chk("tp_bp_y", A, 32'h21);
        chk("tp_bp_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        chk("tp_bp_drain", {31'd0, out_valid}, 32'd0);

        // Flush in FULL with a simultaneous input
        out_ready = 1'b0; in_valid = 1'b1;
        set_op(1, 2, 32'h31, 32'h32, 0, 0, 0, 0, 4'd6, 1'b0);
        cycle();
        set_op(1, 2, 32'h41, 32'h42, 0, 0, 0, 0, 4'd7, 1'b0);
        cycle();
        flush = 1'b1;
        set_op(1, 2, 32'h51, 32'h52, 0, 0, 0, 0, 4'd8, 1'b0);
        cycle();
        chk("tp_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("tp_flush_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("tp_flush_noop", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stall
        out_ready = 1'b0; in_valid = 1'b1;
        set_op(1, 2, 32'h61, 32'h62, 0, 0, 0, 0, 4'd9, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        q.delete();
        stall_model = 0;
        chk("tp_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("tp_rst_A", A, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_state();

        // Random traffic; small index range so forwarding hits often
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 24) == 0;
            set_op(RIDX'($urandom_range(0, 3)), RIDX'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            fwd_ex_en = 1'($urandom_range(0, 1)); fwd_ex_rd = RIDX'($urandom_range(0, 3));
            fwd_ex_data = $urandom;
            fwd_wb_en = 1'($urandom_range(0, 1)); fwd_wb_rd = RIDX'($urandom_range(0, 3));
            fwd_wb_data = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-stage input register that sits directly upstream of the ALU. Drives its A, B, Ctrl and Cin inputs.
- Accepts decoded ops from decode with a valid/ready handshake. Resolves the operand source (register, PC or immediate) and applies EX/WB result forwarding at capture.
- Buffers up to two ops in a skid buffer so in_ready is a registered signal, which breaks the ready path from the ALU consumer back to decode.

Parameters:
- N, 32, datapath width; matches ALU N.
- RIDX, 5, register index width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  decode op valid.
- in_ready  out  1  stage can accept an op; registered.
- in_rs1  in  RIDX  source-1 index.
- in_rs2  in  RIDX  source-2 index.
- in_rs1_data  in  N  regfile source-1 value.
- in_rs2_data  in  N  regfile source-2 value.
- in_pc  in  N  op PC.
- in_imm  in  N  sign-extended immediate.
- in_a_sel  in  1  0 = rs1, 1 = pc.
- in_b_sel  in  1  0 = rs2, 1 = imm.
- in_ctrl  in  4  ALU Ctrl code (0000..1100).
- in_cin  in  1  carry-in; used only for Ctrl 0000.
- fwd_ex_en  in  1  EX result valid for forwarding.
- fwd_ex_rd  in  RIDX  EX destination index.
- fwd_ex_data  in  N  EX result (ALU Res/Cmp).
- fwd_wb_en  in  1  WB write valid.
- fwd_wb_rd  in  RIDX  WB destination index.
- fwd_wb_data  in  N  WB data.
- flush  in  1  discard all buffered ops.
- out_valid  out  1  A/B/Ctrl/Cin hold a valid op.
- out_ready  in  1  ALU/EX consumer accepts.
- A  out  N  ALU operand A.
- B  out  N  ALU operand B.
- Ctrl  out  4  ALU control.
- Cin  out  1  ALU carry-in.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, in_ready=1.
  - A=0, B=0, Ctrl=0000, Cin=0.
  - Skid entry invalid.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Operand resolution (combinational at capture):
  - rs1 value = fwd_ex_data if fwd_ex_en & fwd_ex_rd==in_rs1 & in_rs1!=0; else fwd_wb_data if fwd_wb_en & fwd_wb_rd==in_rs1 & in_rs1!=0; else in_rs1_data. Same rule for rs2.
  - EX has priority over WB.
  - Index 0 never forwards; rs value is in_rsX_data as given.
  - A = in_a_sel ? in_pc : rs1 value.
  - B = in_b_sel ? in_imm : rs2 value.
- Ctrl and Cin:
  - Ctrl is passed unchanged.
  - Cin is forced 0 unless in_ctrl==0000.
  - Undefined codes (1010, 1101..1111) are passed through unchanged; no error.
- State machine (count of valid entries):
  - EMPTY to ONE on input transfer.
  - ONE + input transfer and no output transfer goes to FULL; the op is written to the skid entry and in_ready drops next cycle.
  - ONE + input and output transfer stays ONE; the output register loads the new op.
  - ONE + output transfer only goes to EMPTY.
  - FULL + output transfer goes to ONE; the skid entry moves to the output register and in_ready rises next cycle.
  - in_ready=0 only in FULL.
- Ordering: strict FIFO; an op is never reordered or duplicated.
- Latency: 1 cycle from input transfer to out_valid when empty.
- Output stability: A/B/Ctrl/Cin are held stable while out_valid & !out_ready.
- Forwarding is sampled only at capture. A skid entry is not re-resolved; the decode/hazard unit guarantees no dependency on a still-stalled EX op.
- Flush:
  - Synchronous; next cycle is EMPTY, out_valid=0, in_ready=1.
  - Flush beats a simultaneous input transfer; the incoming op is dropped.
  - Data registers are not cleared.
- Reset mid-transfer: all buffered ops are lost; no output until a new input transfer.

Optional Feature:
- Macro: ALU_ISSUE_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (32 bit).
  - stall_cnt increments each cycle with out_valid & !out_ready, and wraps at 2^32-1 back to 0.
  - Reset value 0; flush does not clear it.
- Undefined: port and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then single op (rs1 data=5, rs2 data=3, ctrl 0000, cin=1, out_ready=1) -> one cycle later out_valid=1, A=5, B=3, Ctrl=0000, Cin=1.
- Ctrl 0011 with in_cin=1 -> Cin=0.
- Forward priority: in_rs1=7, fwd_ex {en=1, rd=7, data=0xAA}, fwd_wb {en=1, rd=7, data=0xBB} -> A=0xAA.
- Forward to x0: in_rs1=0, fwd_ex rd=0, data 0x55, rs1 data=0 -> A=0.
- Operand select: in_a_sel=1, pc=0x100; in_b_sel=1, imm=0xFFFFF800 -> A=0x100, B=0xFFFFF800.
- Backpressure: out_ready=0, send ops X then Y -> in_ready=0 after Y, outputs hold X. Raise out_ready -> X consumed, then Y next cycle, in_ready=1.
  - With ALU_ISSUE_STALL_CNT_EN, stall_cnt equals the stalled cycle count.
- Flush in FULL with simultaneous in_valid -> next cycle out_valid=0, in_ready=1, no op emitted.
- Assert rst mid-stall -> out_valid=0 and A=0 immediately, before the next clock edge.
